// File: rtl/cache_miss_ctrl_if.sv
// cache_miss_ctrl_if: miss request, PHY/MC and cache SRAM signals of the miss handler.
interface cache_miss_ctrl_if #(
    parameter int ADDR_WIDTH       = 32,
    parameter int CLINE_SIZE_WORD  = 4,
    parameter int CLINE_ADDR_WIDTH = 7,
    parameter int CLINE_WORD_WIDTH = 32,
    parameter int NUM_WAYS         = 4
);
    localparam int OFS = $clog2(CLINE_SIZE_WORD);
    localparam int CA  = CLINE_ADDR_WIDTH + OFS;
    localparam int TAG = ADDR_WIDTH - CA;
    localparam int WW  = $clog2(NUM_WAYS);

    logic                             req_vld_i;
    logic                             req_rdy_o;
    logic [ADDR_WIDTH-1:0]            req_addr_i;
    logic [NUM_WAYS-1:0]              req_valid_i;
    logic [NUM_WAYS-1:0]              req_dirty_i;
    logic [TAG*NUM_WAYS-1:0]          req_tags_i;
    logic                             phy_vld_o;
    logic                             phy_rdy_i;
    logic [ADDR_WIDTH:0]              phy_cmd_o;
    logic                             phy_ack_i;
    logic                             phy_wvld_o;
    logic                             phy_wrdy_i;
    logic [CLINE_WORD_WIDTH-1:0]      phy_wdat_o;
    logic                             phy_rvld_i;
    logic [CLINE_WORD_WIDTH-1:0]      phy_rdat_i;
    logic [CA-1:0]                    cache_addr_o;
    logic [NUM_WAYS-1:0]              cache_web_o;
    logic [CLINE_WORD_WIDTH-1:0]      cache_wdat_o;
    logic [CLINE_WORD_WIDTH*NUM_WAYS-1:0] cache_rdat_i;
    logic [CLINE_ADDR_WIDTH-1:0]      tag_addr_o;
    logic [NUM_WAYS-1:0]              tag_web_o;
    logic [TAG:0]                     tag_wdat_o;
    logic                             done_o;
    logic [WW-1:0]                    done_way_o;

    modport master (
        input  req_vld_i, req_addr_i, req_valid_i, req_dirty_i, req_tags_i,
        input  phy_rdy_i, phy_ack_i, phy_wrdy_i, phy_rvld_i, phy_rdat_i, cache_rdat_i,
        output req_rdy_o, phy_vld_o, phy_cmd_o, phy_wvld_o, phy_wdat_o,
        output cache_addr_o, cache_web_o, cache_wdat_o,
        output tag_addr_o, tag_web_o, tag_wdat_o, done_o, done_way_o
    );

    modport slave (
        output req_vld_i, req_addr_i, req_valid_i, req_dirty_i, req_tags_i,
        output phy_rdy_i, phy_ack_i, phy_wrdy_i, phy_rvld_i, phy_rdat_i, cache_rdat_i,
        input  req_rdy_o, phy_vld_o, phy_cmd_o, phy_wvld_o, phy_wdat_o,
        input  cache_addr_o, cache_web_o, cache_wdat_o,
        input  tag_addr_o, tag_web_o, tag_wdat_o, done_o, done_way_o
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: data-cache miss handler; victim select, optional dirty writeback, line refill, tag update.
module cache_miss_ctrl #(
    parameter int ADDR_WIDTH       = 32,
    parameter int CLINE_SIZE_WORD  = 4,
    parameter int CLINE_ADDR_WIDTH = 7,
    parameter int CLINE_WORD_WIDTH = 32,
    parameter int NUM_WAYS         = 4,
    parameter int WB_ENABLE        = 1
) (
    input logic               clk,
    input logic               reset,
    cache_miss_ctrl_if.master bus
);
    localparam int OFS = $clog2(CLINE_SIZE_WORD);
    localparam int CA  = CLINE_ADDR_WIDTH + OFS;
    localparam int TAG = ADDR_WIDTH - CA;
    localparam int WW  = $clog2(NUM_WAYS);
    localparam int W   = CLINE_WORD_WIDTH;

    typedef enum logic [2:0] {IDLE, WB_CMD, WB_RD, WB_SEND, WB_ACK, RD_CMD, RD_DATA, TAG_UPD} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WW-1:0]           vic_q, vic_d, rr_q, rr_d;
    logic                    use_rr_q, use_rr_d;
    logic [TAG-1:0]          vtag_q, vtag_d;
    logic [OFS-1:0]          beat_q, beat_d;
    logic                    ack_q, ack_d, fresh_q, fresh_d;
    logic [W-1:0]            hold_q, hold_d;
    logic [CA-1:0]           caddr_q;
    logic [W-1:0]            cwdat_q;
    logic [ADDR_WIDTH:0]     cmd_q;
    logic [TAG:0]            tdat_q;
    logic [WW-1:0]           dway_q;
    logic [CLINE_ADDR_WIDTH-1:0] idx;
    logic [TAG-1:0]          rtag;
    logic [W-1:0]            slice;
    logic [WW-1:0]           inv_way, new_vic;
    logic                    any_inv;
    logic                    last;

    assign idx   = addr_q[CA-1:OFS];
    assign rtag  = addr_q[ADDR_WIDTH-1:CA];
    assign slice = bus.cache_rdat_i[vic_q*W +: W];
    assign last  = beat_q == OFS'(CLINE_SIZE_WORD - 1);

    always_comb begin
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!bus.req_valid_i[w]) begin
                any_inv = 1'b1;
                inv_way = WW'(w);
            end
        end
        new_vic = any_inv ? inv_way : rr_q;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        vic_d    = vic_q;
        use_rr_d = use_rr_q;
        vtag_d   = vtag_q;
        rr_d     = rr_q;
        beat_d   = beat_q;
        ack_d    = ack_q;
        fresh_d  = 1'b0;
        hold_d   = fresh_q ? slice : hold_q;
        bus.req_rdy_o    = 1'b0;
        bus.phy_vld_o    = 1'b0;
        bus.phy_wvld_o   = 1'b0;
        bus.done_o       = 1'b0;
        bus.cache_web_o  = '1;
        bus.tag_web_o    = '1;
        bus.phy_cmd_o    = cmd_q;
        bus.cache_addr_o = caddr_q;
        bus.cache_wdat_o = cwdat_q;
        bus.tag_wdat_o   = tdat_q;
        bus.done_way_o   = dway_q;
        bus.tag_addr_o   = idx;
        // SRAM data for the WB_RD address appears in the first WB_SEND cycle and is held from then on
        bus.phy_wdat_o   = fresh_q ? slice : hold_q;
        case (state_q)
            IDLE: begin
                bus.req_rdy_o = 1'b1;
                if (bus.req_vld_i) begin
                    addr_d   = bus.req_addr_i;
                    vic_d    = new_vic;
                    use_rr_d = !any_inv;
                    vtag_d   = bus.req_tags_i[new_vic*TAG +: TAG];
                    state_d  = (WB_ENABLE != 0 && bus.req_dirty_i[new_vic]) ? WB_CMD : RD_CMD;
                end
            end
            WB_CMD: begin
                bus.phy_vld_o = 1'b1;
                bus.phy_cmd_o = {1'b1, vtag_q, idx, OFS'(0)};
                state_d       = bus.phy_rdy_i ? WB_RD : WB_CMD;
            end
            WB_RD: begin
                bus.cache_addr_o = {idx, beat_q};
                fresh_d          = 1'b1;
                ack_d            = ack_q | bus.phy_ack_i;
                state_d          = WB_SEND;
            end
            WB_SEND: begin
                bus.phy_wvld_o = 1'b1;
                ack_d          = ack_q | bus.phy_ack_i;
                if (bus.phy_wrdy_i) begin
                    beat_d  = beat_q + OFS'(1);
                    state_d = last ? WB_ACK : WB_RD;
                end
            end
            WB_ACK: begin
                if (bus.phy_ack_i || ack_q) begin
                    ack_d   = 1'b0;
                    state_d = RD_CMD;
                end
            end
            RD_CMD: begin
                bus.phy_vld_o = 1'b1;
                bus.phy_cmd_o = {1'b0, rtag, idx, OFS'(0)};
                if (bus.phy_rdy_i) begin
                    beat_d  = '0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bus.phy_rvld_i) begin
                    bus.cache_web_o  = ~(NUM_WAYS'(1) << vic_q);
                    bus.cache_addr_o = {idx, beat_q};
                    bus.cache_wdat_o = bus.phy_rdat_i;
                    beat_d           = beat_q + OFS'(1);
                    state_d          = last ? TAG_UPD : RD_DATA;
                end
            end
            TAG_UPD: begin
                bus.tag_web_o  = ~(NUM_WAYS'(1) << vic_q);
                bus.tag_wdat_o = {1'b1, rtag};
                bus.done_o     = 1'b1;
                bus.done_way_o = vic_q;
                rr_d           = use_rr_q ? rr_q + WW'(1) : rr_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            vic_q    <= '0;
            use_rr_q <= 1'b0;
            vtag_q   <= '0;
            rr_q     <= '0;
            beat_q   <= '0;
            ack_q    <= 1'b0;
            fresh_q  <= 1'b0;
            hold_q   <= '0;
            caddr_q  <= '0;
            cwdat_q  <= '0;
            cmd_q    <= '0;
            tdat_q   <= '0;
            dway_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            vic_q    <= vic_d;
            use_rr_q <= use_rr_d;
            vtag_q   <= vtag_d;
            rr_q     <= rr_d;
            beat_q   <= beat_d;
            ack_q    <= ack_d;
            fresh_q  <= fresh_d;
            hold_q   <= hold_d;
            caddr_q  <= bus.cache_addr_o;
            cwdat_q  <= bus.cache_wdat_o;
            cmd_q    <= bus.phy_cmd_o;
            tdat_q   <= bus.tag_wdat_o;
            dway_q   <= bus.done_way_o;
        end
    end
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: directed checks of the miss handler in write-back and write-through builds.
module tb_cache_miss_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic         req_vld = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_dirty = '0;
    logic [91:0]  req_tags = '0;
    logic         phy_rdy = 1'b1;
    logic         phy_ack = 1'b0;
    logic         phy_wrdy = 1'b1;
    logic         phy_rvld = 1'b0;
    logic [31:0]  phy_rdat = '0;
    logic [127:0] cache_rdat = '0;

    cache_miss_ctrl_if if1 ();
    cache_miss_ctrl_if if0 ();

    cache_miss_ctrl #(.WB_ENABLE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    cache_miss_ctrl #(.WB_ENABLE(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

    assign if1.req_vld_i = req_vld;     assign if0.req_vld_i = req_vld;
    assign if1.req_addr_i = req_addr;   assign if0.req_addr_i = req_addr;
    assign if1.req_valid_i = req_valid; assign if0.req_valid_i = req_valid;
    assign if1.req_dirty_i = req_dirty; assign if0.req_dirty_i = req_dirty;
    assign if1.req_tags_i = req_tags;   assign if0.req_tags_i = req_tags;
    assign if1.phy_rdy_i = phy_rdy;     assign if0.phy_rdy_i = phy_rdy;
    assign if1.phy_ack_i = phy_ack;     assign if0.phy_ack_i = phy_ack;
    assign if1.phy_wrdy_i = phy_wrdy;   assign if0.phy_wrdy_i = phy_wrdy;
    assign if1.phy_rvld_i = phy_rvld;   assign if0.phy_rvld_i = phy_rvld;
    assign if1.phy_rdat_i = phy_rdat;   assign if0.phy_rdat_i = phy_rdat;
    assign if1.cache_rdat_i = cache_rdat;
    assign if0.cache_rdat_i = cache_rdat;

    // SRAM model, 1-cycle read latency: way w at address a reads 0xA00w_0000 | a
    always @(posedge clk)
        for (int w = 0; w < 4; w++)
            cache_rdat[w*32 +: 32] <= 32'hA000_0000 | (32'(w) << 16) | 32'(if1.cache_addr_o);

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_miss(input logic [31:0] a, input logic [3:0] v, input logic [1:0] way, input string tag);
        logic got;
        got = 1'b0;
        req_vld = 1'b1; req_addr = a; req_valid = v; req_dirty = '0;
        #1;
        chk({tag, "_rdy"}, if1.req_rdy_o, 1);
        cyc();
        req_vld = 1'b0; phy_rvld = 1'b1; phy_rdat = a;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (if1.done_o) begin got = 1'b1; break; end
            cyc();
        end
        chk({tag, "_done"}, got, 1);
        if (got) chk({tag, "_way"}, if1.done_way_o, way);
        phy_rvld = 1'b0;
        cyc();
    endtask

    initial begin
        int nb, st, nw;
        logic got, seen;
        // reset
        repeat (2) cyc();
        reset = 1'b0;
        #1;
        chk("rst_rdy", if1.req_rdy_o, 1);
        chk("rst_vld", if1.phy_vld_o, 0);
        chk("rst_wvld", if1.phy_wvld_o, 0);
        chk("rst_done", if1.done_o, 0);
        chk("rst_web", if1.cache_web_o, 4'hF);
        chk("rst_tweb", if1.tag_web_o, 4'hF);

        // clean miss, all ways invalid
        req_vld = 1'b1; req_addr = 32'h0000_0A34; req_valid = 4'h0; req_dirty = 4'h0;
        #1;
        chk("c_accept", if1.req_rdy_o, 1);
        cyc();
        req_vld = 1'b0;
        #1;
        chk("c_vld", if1.phy_vld_o, 1);
        chk("c_cmd", if1.phy_cmd_o, 33'h0_0000_0A34);
        chk("c_rdy_busy", if1.req_rdy_o, 0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            phy_rvld = 1'b1; phy_rdat = 32'h11 * (k + 1);
            #1;
            chk("c_web", if1.cache_web_o, 4'b1110);
            chk("c_addr", if1.cache_addr_o, 9'h34 + 9'(k));
            chk("c_wdat", if1.cache_wdat_o, 32'h11 * (k + 1));
            chk("c_early_done", if1.done_o, 0);
            cyc();
        end
        phy_rvld = 1'b0;
        #1;
        chk("c_done", if1.done_o, 1);
        chk("c_way", if1.done_way_o, 0);
        chk("c_tweb", if1.tag_web_o, 4'b1110);
        chk("c_tdat", if1.tag_wdat_o, 24'h80_0005);
        chk("c_taddr", if1.tag_addr_o, 7'h0D);
        cyc();
        chk("c_idle", if1.req_rdy_o, 1);
        chk("c_done_pulse", if1.done_o, 0);

        // round robin over all-valid sets
        run_miss(32'h0000_1000, 4'hF, 2'd0, "rr0");
        run_miss(32'h0000_1104, 4'hF, 2'd1, "rr1");
        run_miss(32'h0000_1208, 4'hF, 2'd2, "rr2");
        run_miss(32'h0000_130C, 4'hF, 2'd3, "rr3");
        run_miss(32'h0000_1410, 4'hF, 2'd0, "rr4");
        run_miss(32'h0000_1514, 4'hF, 2'd1, "rr5");

        // dirty victim way 2 (rr_ptr=2), tag 0x12, index 0x10
        req_vld = 1'b1; req_addr = 32'h0000_0C40; req_valid = 4'hF; req_dirty = 4'b0100;
        req_tags = {23'h103, 23'h12, 23'h101, 23'h100};
        #1;
        chk("d_accept", if1.req_rdy_o, 1);
        cyc();
        req_vld = 1'b0;
        #1;
        chk("d_wvld_cmd", if1.phy_vld_o, 1);
        chk("d_wcmd", if1.phy_cmd_o, 33'h1_0000_2440);
        cyc();
        nb = 0; st = 0;
        for (int c = 0; c < 40 && nb < 4; c++) begin
            phy_wrdy = !(nb == 1 && st < 3);
            #1;
            if (if1.phy_wvld_o) begin
                chk("d_wdat", if1.phy_wdat_o, 32'hA002_0040 + 32'(nb));
                if (phy_wrdy) nb++; else st++;
            end
            cyc();
        end
        phy_wrdy = 1'b1;
        chk("d_beats", nb, 4);
        chk("d_stalls", st, 3);
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("d_no_rd_before_ack", if1.phy_vld_o, 0);
            cyc();
        end
        phy_ack = 1'b1;
        #1;
        chk("d_ack_cycle", if1.phy_vld_o, 0);
        cyc();
        phy_ack = 1'b0;
        #1;
        chk("d_rvld_cmd", if1.phy_vld_o, 1);
        chk("d_rcmd", if1.phy_cmd_o, 33'h0_0000_0C40);
        cyc();
        for (int k = 0; k < 4; k++) begin
            phy_rvld = 1'b1; phy_rdat = 32'hD0 + 32'(k);
            #1;
            chk("d_web", if1.cache_web_o, 4'b1011);
            chk("d_addr", if1.cache_addr_o, 9'h40 + 9'(k));
            cyc();
        end
        phy_rvld = 1'b0;
        #1;
        chk("d_done", if1.done_o, 1);
        chk("d_way", if1.done_way_o, 2);
        chk("d_tdat", if1.tag_wdat_o, 24'h80_0006);
        cyc();

        // phy_rdy stall in RD_CMD
        req_vld = 1'b1; req_addr = 32'h0000_0F00; req_valid = 4'h0; req_dirty = 4'h0;
        #1;
        cyc();
        req_vld = 1'b0; phy_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("s_vld", if1.phy_vld_o, 1);
            chk("s_cmd", if1.phy_cmd_o, 33'h0_0000_0F00);
            chk("s_rdy", if1.req_rdy_o, 0);
            cyc();
        end
        phy_rdy = 1'b1;
        #1;
        chk("s_vld_go", if1.phy_vld_o, 1);
        cyc();
        phy_rvld = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (if1.done_o) begin got = 1'b1; break; end
            cyc();
        end
        chk("s_done", got, 1);
        if (got) chk("s_way", if1.done_way_o, 0);
        phy_rvld = 1'b0;
        cyc();

        // reset in RD_DATA after 2 beats (rr_ptr=3 beforehand)
        req_vld = 1'b1; req_addr = 32'h0000_2000; req_valid = 4'hF;
        #1;
        cyc();
        req_vld = 1'b0;
        #1;
        cyc();
        phy_rvld = 1'b1;
        #1;
        chk("r_web_way3", if1.cache_web_o, 4'b0111);
        cyc();
        cyc();
        phy_rvld = 1'b0; reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("r_rdy", if1.req_rdy_o, 1);
        chk("r_vld", if1.phy_vld_o, 0);
        chk("r_wvld", if1.phy_wvld_o, 0);
        chk("r_done", if1.done_o, 0);
        chk("r_web", if1.cache_web_o, 4'hF);
        chk("r_tweb", if1.tag_web_o, 4'hF);
        run_miss(32'h0000_3000, 4'hF, 2'd0, "r_after");

        // write-through build never flushes a dirty victim
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        req_vld = 1'b1; req_addr = 32'h0000_0F00; req_valid = 4'hF; req_dirty = 4'hF;
        #1;
        chk("wt_accept", if0.req_rdy_o, 1);
        cyc();
        req_vld = 1'b0; phy_rvld = 1'b1;
        nw = 0; got = 1'b0; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (if0.phy_wvld_o) nw++;
            if (if0.phy_vld_o && !seen) begin
                seen = 1'b1;
                chk("wt_cmd", if0.phy_cmd_o, 33'h0_0000_0F00);
            end
            if (if0.done_o) begin got = 1'b1; break; end
            cyc();
        end
        chk("wt_cmd_seen", seen, 1);
        chk("wt_done", got, 1);
        chk("wt_no_wvld", nw, 0);
        if (got) chk("wt_way", if0.done_way_o, 0);
        phy_rvld = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
